axi4_mem_responder: RTL

AXI4_MEM_RESPONDER -- requirements
Module: AXI4_MEM_RESPONDER

---
 rtl/pcie_pkg.sv | 41 ++++
 rtl/axi4_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe AXI-side blocks.
//   - AXI response encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   - AXI burst-type encodings (FIXED/INCR/WRAP)
//   - FSM state enums for the memory responder's write and read paths
//   - burst_resp(): base response for a burst, given its range check and burst type
package pcie_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // log2 of the bytes in one memory word (32 B)
  localparam int WORD_BYTES_LG2 = 5;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // An out-of-range address outranks an unsupported WRAP burst.
  function automatic logic [1:0] burst_resp(input logic out_of_range, input logic [1:0] burst);
    if (out_of_range)
      return RESP_DECERR;
    else if (burst == BURST_WRAP)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a 2^MEM_DEPTH_LG2 x DATA_WIDTH flop array. It is the
// responder on the PCIe core's AXI master side. The write path and the read
// path are independent FSMs and may both be active in the same cycle.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   s_axi_aw*                write address channel (cache/prot/qos/region/size ignored)
//   s_axi_w*                 write data channel (byte strobes honoured)
//   s_axi_b*                 write response channel
//   s_axi_ar*                read address channel (cache/prot/qos/region/size ignored)
//   s_axi_r*                 read data channel
module axi4_mem_responder
  import pcie_pkg::*;
#(
  parameter int ID_WIDTH      = 6,
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 256,
  parameter int MEM_DEPTH_LG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,

  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,

  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,

  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,

  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int DEPTH   = 1 << MEM_DEPTH_LG2;
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int IDX_LO  = WORD_BYTES_LG2;
  localparam int IDX_HI  = WORD_BYTES_LG2 + MEM_DEPTH_LG2;
  localparam logic [MEM_DEPTH_LG2-1:0] IDX_ONE = {{(MEM_DEPTH_LG2-1){1'b0}}, 1'b1};
  localparam logic [8:0] BEATS_MAX = 9'h1FF;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Inputs the responder accepts but never acts on.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                           s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
                           s_axi_awsize, s_axi_arsize,
                           s_axi_awaddr[IDX_LO-1:0], s_axi_araddr[IDX_LO-1:0]};

  // ---------------------------------------------------------------- write path
  wr_state_e                  wr_state, wr_next;
  logic [ID_WIDTH-1:0]        wr_id;
  logic [MEM_DEPTH_LG2-1:0]   wr_idx;
  logic [7:0]                 wr_len;
  logic [1:0]                 wr_burst;
  logic [1:0]                 wr_base_resp;
  logic [8:0]                 wr_beats;
  logic [1:0]                 bresp_q;
  logic                       aw_hs, w_hs, b_hs, wr_en;

  assign aw_hs = s_axi_awvalid && (wr_state == W_IDLE);
  assign w_hs  = s_axi_wvalid  && (wr_state == W_DATA);
  assign b_hs  = s_axi_bready  && (wr_state == W_RESP);

  // Beats past awlen+1, and every beat of an errored burst, never reach memory.
  assign wr_en = w_hs && (wr_base_resp == RESP_OKAY) && (wr_beats <= {1'b0, wr_len});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_state <= W_IDLE;
    else
      wr_state <= wr_next;
  end

  always_comb begin
    wr_next       = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) wr_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) wr_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Burst attributes are captured on AW; the response is resolved on the
  // wlast beat, where the final beat count (this beat included) is known.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_id        <= '0;
      wr_idx       <= '0;
      wr_len       <= '0;
      wr_burst     <= BURST_INCR;
      wr_base_resp <= RESP_OKAY;
      wr_beats     <= '0;
      bresp_q      <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        wr_id        <= s_axi_awid;
        wr_idx       <= s_axi_awaddr[IDX_LO +: MEM_DEPTH_LG2];
        wr_len       <= s_axi_awlen;
        wr_burst     <= s_axi_awburst;
        wr_base_resp <= burst_resp(|s_axi_awaddr[ADDR_WIDTH-1:IDX_HI], s_axi_awburst);
        wr_beats     <= '0;
      end
      if (w_hs) begin
        if (wr_burst == BURST_INCR) wr_idx <= wr_idx + IDX_ONE;
        if (wr_beats != BEATS_MAX) wr_beats <= wr_beats + 9'd1;
        if (s_axi_wlast) begin
          if (wr_base_resp != RESP_OKAY)
            bresp_q <= wr_base_resp;
          else if (wr_beats != {1'b0, wr_len})
            bresp_q <= RESP_SLVERR;
          else
            bresp_q <= RESP_OKAY;
        end
      end
      if (b_hs) wr_beats <= '0;
    end
  end

  assign s_axi_bid   = wr_id;
  assign s_axi_bresp = bresp_q;

  // Memory contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (wr_en && s_axi_wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  // ----------------------------------------------------------------- read path
  rd_state_e                  rd_state, rd_next;
  logic [MEM_DEPTH_LG2-1:0]   rd_idx, rd_idx_next;
  logic [7:0]                 rd_len, rd_beat;
  logic [1:0]                 rd_burst;
  logic [ID_WIDTH-1:0]        rid_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic [1:0]                 rresp_q, ar_resp;
  logic                       rlast_q, ar_hs, r_hs;

  assign ar_hs       = s_axi_arvalid && (rd_state == R_IDLE);
  assign r_hs        = s_axi_rready  && (rd_state == R_DATA);
  assign ar_resp     = burst_resp(|s_axi_araddr[ADDR_WIDTH-1:IDX_HI], s_axi_arburst);
  assign rd_idx_next = (rd_burst == BURST_INCR) ? rd_idx + IDX_ONE : rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_state <= R_IDLE;
    else
      rd_state <= rd_next;
  end

  always_comb begin
    rd_next       = rd_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) rd_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && rlast_q) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // The R payload is registered: each word is fetched when the beat before it
  // is accepted, so it stays stable under back-pressure and a same-cycle write
  // to that word is seen only from the following cycle on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_burst <= BURST_INCR;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else if (ar_hs) begin
      rd_idx   <= s_axi_araddr[IDX_LO +: MEM_DEPTH_LG2];
      rd_len   <= s_axi_arlen;
      rd_beat  <= '0;
      rd_burst <= s_axi_arburst;
      rid_q    <= s_axi_arid;
      rresp_q  <= ar_resp;
      rdata_q  <= (ar_resp == RESP_OKAY) ? mem[s_axi_araddr[IDX_LO +: MEM_DEPTH_LG2]] : '0;
      rlast_q  <= (s_axi_arlen == 8'd0);
    end else if (r_hs && !rlast_q) begin
      rd_idx   <= rd_idx_next;
      rd_beat  <= rd_beat + 8'd1;
      rdata_q  <= (rresp_q == RESP_OKAY) ? mem[rd_idx_next] : '0;
      rlast_q  <= ((rd_beat + 8'd1) == rd_len);
    end
  end

  assign s_axi_rid   = rid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rlast = rlast_q;

endmodule
